johnson_decoder: RTL and testbench
==================================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter WIDTH, default 4: Johnson code width N; legal range 2..16.
REQ-002 Parameter LOCK_CNT, default 2: consecutive correct successors needed to lock; range 1..15.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 code_in  input  WIDTH  sampled Johnson code word.
REQ-006 code_valid  input  1  code_in is sampled on this clk edge.
REQ-007 count_out  output  $clog2(2*WIDTH)  decoded index, 0..2N-1.
REQ-008 count_valid  output  1  one-cycle pulse: count_out updated.
REQ-009 illegal  output  1  one-cycle pulse: the sampled word is not one of the 2N legal patterns.
REQ-010 seq_err  output  1  one-cycle pulse: the word is legal but is not the expected successor while in SYNC or LOCKED.
REQ-011 locked  output  1  the FSM is in LOCKED.
REQ-012 dir  output  1  detected direction: 0 = forward, 1 = reverse.
REQ-013 err_cnt  output  8  saturating count of illegal plus seq_err events.

Function
REQ-014 The forward sequence from all-zero shall be next = {~code[0], code[N-1:1]}.
  - N=4: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then wrap to 0000.
REQ-015 A word is legal if it matches one of these forms:
  - ones contiguous from the MSB with zeros below (includes all-zero);
  - zeros contiguous from the MSB with ones below (includes all-ones).
REQ-016 Decode of a legal word (k = number of ones):
  - code[N-1]=1 or code=0: index = k;
  - otherwise: index = 2N-k.
REQ-017 All outputs shall be registered, with latency of exactly 1 clk from a code_valid edge.
  - Cycles without code_valid: pulses low; count_out, locked and dir hold.
REQ-018 An illegal word: illegal=1, count_valid=0, count_out holds, and the FSM goes to HUNT from any state.
REQ-019 FSM states and transitions:
  - HUNT: a legal word moves to SYNC, captures the expected index = (index+1) mod 2N, and clears the match count.
  - SYNC: a match increments the match count; reaching LOCK_CNT moves to LOCKED; a mismatch pulses seq_err and re-seeds SYNC from the received word.
  - LOCKED: a match stays in LOCKED; a mismatch pulses seq_err and moves to HUNT.
REQ-020 Index wrap: expected after 2N-1 shall be 0, with no error.
REQ-021 A repeated identical word counts as a mismatch (seq_err).
REQ-022 count_valid=1 for every legal sampled word, in all states.
REQ-023 err_cnt shall saturate at 255 and never wrap.
  - illegal and seq_err are mutually exclusive, so each sample adds at most 1.

Reset
REQ-024 While reset=0 at a clk edge, the block shall return to its reset values regardless of code_valid, including mid-sequence:
  - state HUNT;
  - count_out, err_cnt, match count and expected index = 0;
  - all pulses, locked and dir = 0.

Configuration
REQ-025 With JOHNSON_DEC_DIR_EN defined, the reverse successor ((index-1) mod 2N) shall also be accepted, as follows:
  - In HUNT, the direction of the 2nd legal word sets dir.
  - In SYNC or LOCKED, a word matching the opposite direction counts as a mismatch.
REQ-026 Without JOHNSON_DEC_DIR_EN, dir shall be tied to 0 and reverse steps shall raise seq_err.

Structure
REQ-027 Package johnson_pkg shall hold:
  - the FSM state enum {HUNT, SYNC, LOCKED};
  - the count-width localparam function;
  - the ERR_MAX=255 constant.
REQ-028 Combinational sub-module johnson_code_check shall own legality checking and index decode (inputs code; outputs legal and index); all sequential logic stays in johnson_decoder.

Verification
REQ-029 N=4, LOCK_CNT=2, drive 0000, 1000, 1100, 1110, ... for 10 words -> count_out 0,1,2,3,...,7,0,1; locked rises 1 clk after the 3rd word; err_cnt=0.
REQ-030 In LOCKED at index 3 (1110), drive 1010 -> illegal=1, count_out holds 3, locked=0 the next cycle, err_cnt=1.
REQ-031 In LOCKED at 0011 (index 6), drive 1100 -> seq_err=1, count_out=2, state HUNT, err_cnt increments.
REQ-032 Force 300 illegal words (0101) -> err_cnt stops at 255.
REQ-033 With JOHNSON_DEC_DIR_EN, drive 0000, 0001, 0011, 0111 -> dir=1, locked=1, count_out 0,7,6,5; without the macro the same stimulus -> seq_err pulses and locked=0.
REQ-034 Assert reset=0 for one edge while LOCKED with code_valid=1 -> every output reads its reset value on the next cycle.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code decoder slice.
// Holds the FSM state encoding, the count-width helper and the
// saturation limit of the error counter.
package johnson_pkg;

   // Synchroniser FSM states
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Ceiling value of the 8-bit error counter
   localparam logic [7:0] ERR_MAX = 8'd255;

   // Width of a decoded index for a Johnson code of 'width' bits (2N states)
   function automatic int cnt_w(input int width);
      return $clog2(2 * width);
   endfunction

   // Saturating increment of the error counter
   function automatic logic [7:0] err_sat_inc(input logic [7:0] cnt);
      logic [7:0] res;
      if (cnt == ERR_MAX) begin
         res = cnt;
      end else begin
         res = cnt + 8'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Bus between a Johnson code source and the decoder.
// master: drives sampled code words and reads decode results.
// slave : the decoder side.
interface johnson_decoder_if #(
   parameter int WIDTH = 4
);
   localparam int CW = johnson_pkg::cnt_w(WIDTH);

   logic [WIDTH-1:0] code_in;
   logic             code_valid;
   logic [CW-1:0]    count_out;
   logic             count_valid;
   logic             illegal;
   logic             seq_err;
   logic             locked;
   logic             dir;
   logic [7:0]       err_cnt;

   modport master (
      output code_in,
      output code_valid,
      input  count_out,
      input  count_valid,
      input  illegal,
      input  seq_err,
      input  locked,
      input  dir,
      input  err_cnt
   );

   modport slave (
      input  code_in,
      input  code_valid,
      output count_out,
      output count_valid,
      output illegal,
      output seq_err,
      output locked,
      output dir,
      output err_cnt
   );

endinterface

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode of one Johnson code word.
// A word is legal when it has at most one 0/1 transition between adjacent
// bits: that covers "ones from MSB, zeros below" and "zeros from MSB, ones
// below", including all-zero and all-ones.
// Index: k ones; MSB set or all-zero -> k, otherwise 2N-k.
module johnson_code_check
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]          code,
   output logic                      legal,
   output logic [cnt_w(WIDTH)-1:0]   index
);

   localparam int CW = cnt_w(WIDTH);
   // 2N reduced modulo 2^CW; the subtraction below wraps the same way,
   // so 2N-k comes out right even when 2N equals 2^CW.
   localparam logic [CW-1:0] TWO_N = CW'(2 * WIDTH);

   logic [CW-1:0] ones_s;
   logic [CW-1:0] trans_s;

   // Count ones and adjacent-bit transitions, then classify and decode
   always_comb begin
      ones_s  = {CW{1'b0}};
      trans_s = {CW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         ones_s = ones_s + CW'(code[i]);
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (code[i] != code[i+1]) begin
            trans_s = trans_s + CW'(1);
         end else begin
            trans_s = trans_s;
         end
      end

      legal = (trans_s <= CW'(1));

      if (code[WIDTH-1] || (ones_s == {CW{1'b0}})) begin
         index = ones_s;
      end else begin
         index = TWO_N - ones_s;
      end
   end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking.
// Decodes each sampled word to its index, flags illegal words and
// out-of-sequence words, and locks after LOCK_CNT consecutive correct
// successors. All outputs are registered, one clk after code_valid.
// Optional feature: define JOHNSON_DEC_DIR_EN to also accept the reverse
// successor; the second legal word after a seed picks the direction.
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 2
) (
   input logic               clk,
   input logic               reset,
   johnson_decoder_if.slave  bus
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(2 * WIDTH - 1);
   localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

`ifdef JOHNSON_DEC_DIR_EN
   localparam logic DIR_EN = 1'b1;
`else
   localparam logic DIR_EN = 1'b0;
`endif

   // Registered state and outputs
   state_t        state_r;
   logic [CW-1:0] exp_r;
   logic [3:0]    match_r;
   logic [CW-1:0] count_r;
   logic [7:0]    err_cnt_r;
   logic          valid_r;
   logic          illegal_r;
   logic          seq_err_r;
   logic          locked_r;
   logic          dir_r;
   logic          dir_known_r;

   // Decode and next-step helpers
   logic          legal_s;
   logic [CW-1:0] idx_s;
   logic [CW-1:0] idx_inc_s;
   logic [CW-1:0] idx_dec_s;
   logic [CW-1:0] cnt_dec_s;
   logic          exp_hit_s;
   logic          rev_hit_s;
   logic          hit_s;
   logic          dir_nxt_s;
   logic [CW-1:0] step_exp_s;
   logic [3:0]    match_inc_s;

   johnson_code_check #(
      .WIDTH (WIDTH)
   ) u_check (
      .code  (bus.code_in),
      .legal (legal_s),
      .index (idx_s)
   );

   // Modular +1/-1 of the received index and -1 of the previous index
   always_comb begin
      if (idx_s == LAST_IDX) begin
         idx_inc_s = {CW{1'b0}};
      end else begin
         idx_inc_s = idx_s + CW'(1);
      end
      if (idx_s == {CW{1'b0}}) begin
         idx_dec_s = LAST_IDX;
      end else begin
         idx_dec_s = idx_s - CW'(1);
      end
      if (count_r == {CW{1'b0}}) begin
         cnt_dec_s = LAST_IDX;
      end else begin
         cnt_dec_s = count_r - CW'(1);
      end
   end

   // Successor match: expected index, or (direction still open) the reverse step
   always_comb begin
      exp_hit_s   = (idx_s == exp_r);
      rev_hit_s   = DIR_EN && !dir_known_r && (idx_s == cnt_dec_s);
      hit_s       = exp_hit_s || rev_hit_s;
      match_inc_s = match_r + 4'd1;
      if (rev_hit_s) begin
         dir_nxt_s = 1'b1;
      end else if (DIR_EN && dir_known_r) begin
         dir_nxt_s = dir_r;
      end else begin
         dir_nxt_s = 1'b0;
      end
      if (dir_nxt_s) begin
         step_exp_s = idx_dec_s;
      end else begin
         step_exp_s = idx_inc_s;
      end
   end

   // Synchroniser FSM with registered decode, pulse and counter outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= HUNT;
         exp_r       <= {CW{1'b0}};
         match_r     <= 4'd0;
         count_r     <= {CW{1'b0}};
         err_cnt_r   <= 8'd0;
         valid_r     <= 1'b0;
         illegal_r   <= 1'b0;
         seq_err_r   <= 1'b0;
         locked_r    <= 1'b0;
         dir_r       <= 1'b0;
         dir_known_r <= 1'b0;
      end else begin
         valid_r   <= 1'b0;
         illegal_r <= 1'b0;
         seq_err_r <= 1'b0;
         if (bus.code_valid) begin
            if (!legal_s) begin
               // Illegal word: count_out holds, drop back to HUNT
               illegal_r   <= 1'b1;
               state_r     <= HUNT;
               locked_r    <= 1'b0;
               match_r     <= 4'd0;
               dir_known_r <= 1'b0;
               err_cnt_r   <= err_sat_inc(err_cnt_r);
            end else begin
               valid_r <= 1'b1;
               count_r <= idx_s;
               case (state_r)
                  HUNT: begin
                     state_r     <= SYNC;
                     exp_r       <= idx_inc_s;
                     match_r     <= 4'd0;
                     dir_known_r <= 1'b0;
                  end
                  SYNC: begin
                     if (hit_s) begin
                        exp_r       <= step_exp_s;
                        dir_r       <= dir_nxt_s;
                        dir_known_r <= 1'b1;
                        match_r     <= match_inc_s;
                        if (match_inc_s >= LOCK_TGT) begin
                           state_r  <= LOCKED;
                           locked_r <= 1'b1;
                        end else begin
                           state_r  <= SYNC;
                        end
                     end else begin
                        // Re-seed from the received word
                        seq_err_r   <= 1'b1;
                        exp_r       <= idx_inc_s;
                        match_r     <= 4'd0;
                        dir_known_r <= 1'b0;
                        err_cnt_r   <= err_sat_inc(err_cnt_r);
                     end
                  end
                  LOCKED: begin
                     if (hit_s) begin
                        exp_r <= step_exp_s;
                        dir_r <= dir_nxt_s;
                     end else begin
                        seq_err_r   <= 1'b1;
                        state_r     <= HUNT;
                        locked_r    <= 1'b0;
                        match_r     <= 4'd0;
                        dir_known_r <= 1'b0;
                        err_cnt_r   <= err_sat_inc(err_cnt_r);
                     end
                  end
                  default: begin
                     state_r     <= HUNT;
                     locked_r    <= 1'b0;
                     match_r     <= 4'd0;
                     dir_known_r <= 1'b0;
                  end
               endcase
            end
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign bus.count_out   = count_r;
   assign bus.count_valid = valid_r;
   assign bus.illegal     = illegal_r;
   assign bus.seq_err     = seq_err_r;
   assign bus.locked      = locked_r;
   assign bus.dir         = DIR_EN ? dir_r : 1'b0;
   assign bus.err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed self-checking bench for johnson_decoder (WIDTH=4, LOCK_CNT=2).
// Direction expectations follow JOHNSON_DEC_DIR_EN when it is defined.
module tb_johnson_decoder;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   passes = 0;

   johnson_decoder_if #(.WIDTH(4)) bus ();

   johnson_decoder #(
      .WIDTH    (4),
      .LOCK_CNT (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [3:0] w);
      @(negedge clk);
      bus.code_in    = w;
      bus.code_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.code_valid = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.code_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b0;
      bus.code_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({bus.count_out, bus.count_valid, bus.illegal, bus.seq_err, bus.locked, bus.dir, bus.err_cnt} !== 16'd0)
         $display("FAIL %s outputs: count=%0d cv=%0b ill=%0b se=%0b lk=%0b dir=%0b err=%0d want all 0", tag,
                  bus.count_out, bus.count_valid, bus.illegal, bus.seq_err, bus.locked, bus.dir, bus.err_cnt);
      else passes++;
   endtask

   task automatic test_reset();
      do_reset();
      idle();
      check_all_zero("reset");
   endtask

   task automatic test_forward();
      logic [3:0] seq [10] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
      logic [2:0] exp_idx [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send(seq[i]);
         checks++;
         if (bus.count_out !== exp_idx[i] || bus.count_valid !== 1'b1 || bus.seq_err !== 1'b0)
            $display("FAIL fwd word %0d: count=%0d cv=%0b se=%0b want count=%0d cv=1 se=0",
                     i, bus.count_out, bus.count_valid, bus.seq_err, exp_idx[i]);
         else passes++;
         checks++;
         if (bus.locked !== (i >= 2))
            $display("FAIL fwd locked word %0d: got %0b want %0b", i, bus.locked, (i >= 2));
         else passes++;
      end
      checks++;
      if (bus.err_cnt !== 8'd0) $display("FAIL fwd err_cnt: got %0d want 0", bus.err_cnt);
      else passes++;
      idle();
      checks++;
      if (bus.count_valid !== 1'b0 || bus.count_out !== 3'd1 || bus.locked !== 1'b1)
         $display("FAIL idle hold: cv=%0b count=%0d lk=%0b want cv=0 count=1 lk=1",
                  bus.count_valid, bus.count_out, bus.locked);
      else passes++;
   endtask

   task automatic test_illegal();
      do_reset();
      send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1110);
      send(4'b1010);
      checks++;
      if (bus.illegal !== 1'b1 || bus.count_valid !== 1'b0 || bus.count_out !== 3'd3)
         $display("FAIL illegal pulse: ill=%0b cv=%0b count=%0d want ill=1 cv=0 count=3",
                  bus.illegal, bus.count_valid, bus.count_out);
      else passes++;
      checks++;
      if (bus.locked !== 1'b0 || bus.err_cnt !== 8'd1 || bus.seq_err !== 1'b0)
         $display("FAIL illegal state: lk=%0b err=%0d se=%0b want lk=0 err=1 se=0",
                  bus.locked, bus.err_cnt, bus.seq_err);
      else passes++;
   endtask

   task automatic test_seq_err();
      do_reset();
      send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1110);
      send(4'b1111); send(4'b0111); send(4'b0011);
      send(4'b1100);
      checks++;
      if (bus.seq_err !== 1'b1 || bus.count_out !== 3'd2 || bus.count_valid !== 1'b1 ||
          bus.locked !== 1'b0 || bus.err_cnt !== 8'd1)
         $display("FAIL seq_err: se=%0b count=%0d cv=%0b lk=%0b err=%0d want se=1 count=2 cv=1 lk=0 err=1",
                  bus.seq_err, bus.count_out, bus.count_valid, bus.locked, bus.err_cnt);
      else passes++;
      // From HUNT, three words are needed to lock again
      send(4'b1110);
      send(4'b1111);
      checks++;
      if (bus.locked !== 1'b0 || bus.seq_err !== 1'b0)
         $display("FAIL hunt after seq_err: lk=%0b se=%0b want lk=0 se=0", bus.locked, bus.seq_err);
      else passes++;
      send(4'b0111);
      checks++;
      if (bus.locked !== 1'b1) $display("FAIL relock: got %0b want 1", bus.locked);
      else passes++;
      // Repeated word counts as a mismatch
      send(4'b0111);
      checks++;
      if (bus.seq_err !== 1'b1 || bus.locked !== 1'b0 || bus.count_out !== 3'd5 || bus.err_cnt !== 8'd2)
         $display("FAIL repeat: se=%0b lk=%0b count=%0d err=%0d want se=1 lk=0 count=5 err=2",
                  bus.seq_err, bus.locked, bus.count_out, bus.err_cnt);
      else passes++;
   endtask

   task automatic test_reseed();
      do_reset();
      send(4'b0000);
      send(4'b1100);
      checks++;
      if (bus.seq_err !== 1'b1 || bus.count_out !== 3'd2)
         $display("FAIL reseed mismatch: se=%0b count=%0d want se=1 count=2", bus.seq_err, bus.count_out);
      else passes++;
      send(4'b1110);
      send(4'b1111);
      checks++;
      if (bus.locked !== 1'b1 || bus.seq_err !== 1'b0 || bus.err_cnt !== 8'd1)
         $display("FAIL reseed lock: lk=%0b se=%0b err=%0d want lk=1 se=0 err=1",
                  bus.locked, bus.seq_err, bus.err_cnt);
      else passes++;
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         send(4'b0101);
         if (i == 254 || i == 255 || i == 256 || i == 300) begin
            checks++;
            if (bus.err_cnt !== ((i < 255) ? 8'(i) : 8'd255) || bus.illegal !== 1'b1)
               $display("FAIL saturate after %0d: err=%0d ill=%0b want err=%0d ill=1",
                        i, bus.err_cnt, bus.illegal, ((i < 255) ? i : 255));
            else passes++;
         end
      end
   endtask

   task automatic test_direction();
      logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
      logic [2:0] exp_idx [4] = '{3'd0, 3'd7, 3'd6, 3'd5};
      int seq_errs = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(seq[i]);
         if (bus.seq_err === 1'b1) seq_errs++;
         checks++;
         if (bus.count_out !== exp_idx[i])
            $display("FAIL dir count word %0d: got %0d want %0d", i, bus.count_out, exp_idx[i]);
         else passes++;
      end
`ifdef JOHNSON_DEC_DIR_EN
      checks++;
      if (bus.dir !== 1'b1 || bus.locked !== 1'b1 || seq_errs != 0)
         $display("FAIL reverse: dir=%0b lk=%0b seq_errs=%0d want dir=1 lk=1 seq_errs=0",
                  bus.dir, bus.locked, seq_errs);
      else passes++;
`else
      checks++;
      if (bus.dir !== 1'b0 || bus.locked !== 1'b0 || seq_errs != 3 || bus.err_cnt !== 8'd3)
         $display("FAIL reverse: dir=%0b lk=%0b seq_errs=%0d err=%0d want dir=0 lk=0 seq_errs=3 err=3",
                  bus.dir, bus.locked, seq_errs, bus.err_cnt);
      else passes++;
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(4'b0000); send(4'b1000); send(4'b1100); send(4'b1010); // err_cnt=1
      send(4'b0000); send(4'b1000); send(4'b1100);
      checks++;
      if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd1)
         $display("FAIL pre-reset: lk=%0b err=%0d want lk=1 err=1", bus.locked, bus.err_cnt);
      else passes++;
      @(negedge clk);
      reset          = 1'b0;
      bus.code_in    = 4'b1110;
      bus.code_valid = 1'b1;
      @(posedge clk);
      #1;
      reset          = 1'b1;
      bus.code_valid = 1'b0;
      check_all_zero("reset mid");
      // Fresh start after reset needs a full three-word lock-in
      send(4'b1110);
      send(4'b1111);
      checks++;
      if (bus.locked !== 1'b0 || bus.count_out !== 3'd4)
         $display("FAIL post-reset relock: lk=%0b count=%0d want lk=0 count=4", bus.locked, bus.count_out);
      else passes++;
   endtask

   initial begin
      bus.code_in    = 4'b0000;
      bus.code_valid = 1'b0;
      test_reset();
      test_forward();
      test_illegal();
      test_seq_err();
      test_reseed();
      test_saturate();
      test_direction();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
